// File: rtl/serial_term_rx_if.sv
// serial_term_rx_if: groups the serial line input and the FIFO drain/status
// signals of serial_term_rx into one bundle.
//   master : the side that drives the line and drains bytes (terminal/bench)
//            drives rx, rd_en, clr_ovf; observes dout, empty, count, busy,
//            frame_err, overflow (and break_det when enabled).
//   slave  : the receiver itself (serial_term_rx).
// Optional: SERIAL_TERM_RX_BREAK_DETECT_EN adds the break_det pulse.
interface serial_term_rx_if #(
   parameter int unsigned FIFO_DEPTH = 16
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic          rx;
   logic          rd_en;
   logic          clr_ovf;
   logic [7:0]    dout;
   logic          empty;
   logic [CW-1:0] count;
   logic          busy;
   logic          frame_err;
   logic          overflow;
`ifdef SERIAL_TERM_RX_BREAK_DETECT_EN
   logic          break_det;

   modport master (
      output rx, rd_en, clr_ovf,
      input  dout, empty, count, busy, frame_err, overflow, break_det
   );

   modport slave (
      input  rx, rd_en, clr_ovf,
      output dout, empty, count, busy, frame_err, overflow, break_det
   );
`else
   modport master (
      output rx, rd_en, clr_ovf,
      input  dout, empty, count, busy, frame_err, overflow
   );

   modport slave (
      input  rx, rd_en, clr_ovf,
      output dout, empty, count, busy, frame_err, overflow
   );
`endif
endinterface

// File: rtl/serial_term_rx.sv
// serial_term_rx: UART 8N1 receiver for the Altair SIO transmit line, feeding
// a first-word-fall-through byte FIFO drained by the terminal logic.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   bus.rx     asynchronous serial line (idle high), synchronised internally
//   bus.rd_en  pop head byte (ignored when empty)
//   bus.clr_ovf clear the sticky overflow flag
//   bus.dout   head byte, valid while empty=0
//   bus.empty / bus.count  FIFO status
//   bus.busy   receiver not idle
//   bus.frame_err  one-cycle pulse on a bad stop bit
//   bus.overflow   sticky, a good byte was dropped on a full FIFO
// Optional: SERIAL_TERM_RX_BREAK_DETECT_EN adds bus.break_det, a one-cycle
// pulse for an all-zero frame, re-armed after a full bit time of idle line.
module serial_term_rx #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input logic             clk,
   input logic             reset,
   serial_term_rx_if.slave bus
);
   localparam int unsigned CPB  = CLK_HZ / BAUD;
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned CTW  = $clog2(CPB);
   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t         state, state_nx;
   logic [CTW-1:0] tick, tick_nx;
   logic [2:0]     bit_idx, bit_idx_nx;
   logic [7:0]     shreg, shreg_nx;
   logic           rx_meta, rxs, rxs_d;
   logic           push_c, ferr_c;
   logic           busy_q, ferr_q;
`ifdef SERIAL_TERM_RX_BREAK_DETECT_EN
   logic           brk_c, brk_q;
   logic           brk_hold, brk_hold_nx;
`endif

   // Line synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d   <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rxs     <= rx_meta;
         rxs_d   <= rxs;
      end
   end

   // Receiver state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         tick    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         busy_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SERIAL_TERM_RX_BREAK_DETECT_EN
         brk_q    <= 1'b0;
         brk_hold <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         tick    <= tick_nx;
         bit_idx <= bit_idx_nx;
         shreg   <= shreg_nx;
         busy_q  <= (state_nx != S_IDLE);
         ferr_q  <= ferr_c;
`ifdef SERIAL_TERM_RX_BREAK_DETECT_EN
         brk_q    <= brk_c;
         brk_hold <= brk_hold_nx;
`endif
      end
   end

   // Receiver next-state: tick counts down to each sample point
   always_comb begin
      state_nx   = state;
      tick_nx    = tick;
      bit_idx_nx = bit_idx;
      shreg_nx   = shreg;
      push_c     = 1'b0;
      ferr_c     = 1'b0;
`ifdef SERIAL_TERM_RX_BREAK_DETECT_EN
      brk_c       = 1'b0;
      brk_hold_nx = brk_hold;
`endif
      unique case (state)
         S_IDLE: begin
            if (rxs_d && !rxs) begin
               tick_nx  = CTW'(HALF - 1);
               state_nx = S_START;
            end
         end
         S_START: begin
            if (tick == '0) begin
               if (rxs) begin
                  state_nx = S_IDLE;
               end else begin
                  tick_nx    = CTW'(CPB - 1);
                  bit_idx_nx = '0;
                  state_nx   = S_DATA;
               end
            end else begin
               tick_nx = tick - CTW'(1);
            end
         end
         S_DATA: begin
            if (tick == '0) begin
               shreg_nx = {rxs, shreg[7:1]};
               tick_nx  = CTW'(CPB - 1);
               if (bit_idx == 3'd7) begin
                  state_nx = S_STOP;
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
               end
            end else begin
               tick_nx = tick - CTW'(1);
            end
         end
         S_STOP: begin
            if (tick == '0) begin
               if (rxs) begin
                  push_c   = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  ferr_c   = 1'b1;
                  state_nx = S_WAIT_HIGH;
`ifdef SERIAL_TERM_RX_BREAK_DETECT_EN
                  if (shreg == 8'h00) begin
                     brk_c       = 1'b1;
                     brk_hold_nx = 1'b1;
                     tick_nx     = CTW'(CPB - 1);
                  end
`endif
               end
            end else begin
               tick_nx = tick - CTW'(1);
            end
         end
         S_WAIT_HIGH: begin
`ifdef SERIAL_TERM_RX_BREAK_DETECT_EN
            // After a break, require a full bit time of continuous idle
            if (brk_hold) begin
               if (!rxs) begin
                  tick_nx = CTW'(CPB - 1);
               end else if (tick == '0) begin
                  brk_hold_nx = 1'b0;
                  state_nx    = S_IDLE;
               end else begin
                  tick_nx = tick - CTW'(1);
               end
            end else if (rxs) begin
               state_nx = S_IDLE;
            end
`else
            if (rxs) begin
               state_nx = S_IDLE;
            end
`endif
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // FWFT FIFO: dout is registered as the head after this cycle's push/pop
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
   logic [CW-1:0] cnt_q, remain_c, cnt_nx;
   logic [7:0]    dout_q, dout_nx;
   logic          empty_q, ovf_q;
   logic          full_c, pop_c, wr_c, ovf_set_c;

   always_comb begin
      full_c    = (cnt_q == CW'(FIFO_DEPTH));
      pop_c     = bus.rd_en && !empty_q;
      wr_c      = push_c && (!full_c || pop_c);
      ovf_set_c = push_c && full_c && !pop_c;
      rd_ptr_nx = rd_ptr + PW'(pop_c);
      remain_c  = cnt_q - CW'(pop_c);
      cnt_nx    = remain_c + CW'(wr_c);
      dout_nx   = dout_q;
      if (remain_c == '0) begin
         if (wr_c) begin
            dout_nx = shreg;
         end
      end else begin
         dout_nx = mem[rd_ptr_nx];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_c) begin
         mem[wr_ptr] <= shreg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr + PW'(wr_c);
         rd_ptr  <= rd_ptr_nx;
         cnt_q   <= cnt_nx;
         dout_q  <= dout_nx;
         empty_q <= (cnt_nx == '0);
         // Set has priority over a simultaneous clear
         if (ovf_set_c) begin
            ovf_q <= 1'b1;
         end else if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.dout      = dout_q;
   assign bus.empty     = empty_q;
   assign bus.count     = cnt_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = ferr_q;
   assign bus.overflow  = ovf_q;
`ifdef SERIAL_TERM_RX_BREAK_DETECT_EN
   assign bus.break_det = brk_q;
`endif

endmodule
